mcm_engine: RTL
===============

Name: mcm_engine

Overview:
- Parametrised, single-clock matrix-chain-order engine: one block replacing the separate dimension store, loop iterator, cost datapath and solution store.
- Host streams N+1 dimensions p[0..N], pulses start, and the engine fills the DP tables m[i][j] (minimum scalar multiplications) and s[i][j] (optimal split k).
- Results are then read back through a registered query port.
- Adds capacity, cost width, start/done handshake, saturation and error reporting.

Parameters:
- MAX_N, 8, maximum number of matrices in a chain; 1..254.
- DIM_W, 8, width of one dimension value.
- COST_W, 32, width of stored cost; must be ≥ 1.

Ports:
- clk1  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of loaded-dimension count; honoured only in IDLE.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DIM_W  next dimension p[cnt].
- load_ready  out  1  high in IDLE when cnt < MAX_N+1.
- start  in  1  begin computation; sampled only in IDLE.
- busy  out  1  high in INIT/COMPUTE/WRITE/DONE.
- done  out  1  one-cycle pulse when tables are complete.
- err  out  1  one-cycle pulse when start is issued with cnt < 2.
- num_mats  out  8  N of the last completed run.
- q_valid  in  1  query request.
- q_i, q_j  in  8  query indices (1-based).
- q_rvalid  out  1  registered response strobe.
- q_cost  out  COST_W  m[q_i][q_j].
- q_split  out  8  s[q_i][q_j].

Behaviour:
- Reset values: state = IDLE; cnt = 0; busy, done, err, q_rvalid = 0; num_mats = 0; q_cost = 0; q_split = 0. Table contents are undefined until the first done.
- Load:
  - A transfer occurs when load_valid && load_ready. It writes p[cnt] and increments cnt.
  - With load_ready low, load_valid is ignored.
  - If clr and a load occur in the same cycle, clr wins (cnt = 0, data dropped).
- Start, evaluated in IDLE:
  - cnt < 2: pulse err, stay in IDLE.
  - Otherwise latch N = cnt−1 and go to INIT.
  - Simultaneous start and load: the load is taken first and start sees the updated cnt on the next cycle only; the start in that cycle is ignored.
- INIT (1 cycle): m[i][i] = 0 and s[i][i] = 0 for i = 1..N. Set L = 2, i = 1, k = i. If N = 1, go directly to DONE.
- COMPUTE (one k per cycle), with j = i+L−1:
  - cand = m[i][k] + m[k+1][j] + p[i−1]·p[k]·p[j].
  - The product is computed at 3·DIM_W bits; the sum saturates at 2^COST_W−1.
  - First k loads best; later k replace best only if cand < best (strict), so ties keep the smallest k.
  - After k = j−1, go to WRITE.
- WRITE (1 cycle):
  - Store m[i][j] = best and s[i][j] = argmin k.
  - Advance: i++. If i > N−L+1, then L++ and i = 1. If L > N, go to DONE; else set k = i and return to COMPUTE.
- DONE (1 cycle): done = 1, num_mats = N, return to IDLE. cnt is retained, so start may rerun on the same data.
- Latency: done is high exactly T = 2 + Σ_{L=2..N} (N−L+1)·L cycles after the cycle start was accepted.
- Query:
  - Accepted only in IDLE. In any other state q_rvalid stays 0 and the query is dropped.
  - Response one cycle later: q_rvalid = 1 with q_cost and q_split.
  - If q_i = 0, q_j > num_mats, or q_i > q_j, respond with q_cost = 0 and q_split = 0.
- rst mid-operation: abort immediately to IDLE, cnt = 0, no done pulse. clr outside IDLE is ignored.
- Table storage: MAX_N × MAX_N entries each for m and s; registers or inferred RAM, but the read must not add latency beyond the COMPUTE timing stated above.

Test Plan:
- Load 10,30,5,60 and start → done at start+9 with num_mats = 3. Queries return (1,2) = 1500 s1; (2,3) = 9000 s2; (1,3) = 4500 s2.
- Load 30,35,15,5,10,20,25 and start → done at start+52; (1,6) = 15125 s3; (2,5) = 7125 s3.
- Tie case: load 1,1,1,1 → (1,3) = 2, s = 1 (smallest k kept).
- Build with COST_W = 16, load 255,255,255 → (1,2) = 65535 (saturated). Load only 7 → start pulses err, busy stays 0.
- Load MAX_N+1 values → load_ready drops and a further load_valid is ignored. Query (3,2) → 0/0. A query during busy yields no q_rvalid.
- Assert rst in the middle of COMPUTE → busy = 0 on the next cycle, no done pulse, load_ready = 1, cnt = 0; a subsequent full run gives correct results.

Source files
------------

// File: rtl/mcm_engine_if.sv
// Host-side bus of the matrix-chain-order engine: dimension load, start/status and the
// registered table query port.
interface mcm_engine_if #(
    parameter int DIM_W  = 8,
    parameter int COST_W = 32
);
    logic              clr;
    logic              load_valid;
    logic [DIM_W-1:0]  load_data;
    logic              load_ready;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        num_mats;
    logic              q_valid;
    logic [7:0]        q_i;
    logic [7:0]        q_j;
    logic              q_rvalid;
    logic [COST_W-1:0] q_cost;
    logic [7:0]        q_split;

    modport master (
        output clr, load_valid, load_data, start, q_valid, q_i, q_j,
        input  load_ready, busy, done, err, num_mats, q_rvalid, q_cost, q_split
    );

    modport slave (
        input  clr, load_valid, load_data, start, q_valid, q_i, q_j,
        output load_ready, busy, done, err, num_mats, q_rvalid, q_cost, q_split
    );
endinterface

// File: rtl/mcm_engine.sv
// Matrix-chain-order DP engine: evaluates one split k per cycle into register-file
// tables m (min cost, saturating) and s (argmin split), then serves indexed queries.
module mcm_engine #(
    parameter int MAX_N  = 8,
    parameter int DIM_W  = 8,
    parameter int COST_W = 32
) (
    input  logic          clk1,
    input  logic          rst,
    mcm_engine_if.slave   bus
);
    localparam int IW = 9;
    localparam int PW = 3 * DIM_W;
    localparam int SW = ((COST_W > PW) ? COST_W : PW) + 2;
    localparam int AP = $clog2(MAX_N + 1);
    localparam int AM = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [IW-1:0] ONE = IW'(1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_COMPUTE, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [IW-1:0]     r_cnt, r_n, r_len, r_i, r_k;
    logic [DIM_W-1:0]  r_p [0:MAX_N];
    logic [COST_W-1:0] r_m [0:MAX_N-1][0:MAX_N-1];
    logic [7:0]        r_s [0:MAX_N-1][0:MAX_N-1];
    logic [COST_W-1:0] r_best;
    logic [7:0]        r_best_k;
    logic              r_err, r_qv;
    logic [7:0]        r_num, r_qsplit;
    logic [COST_W-1:0] r_qcost;

    logic              w_busy, w_done, w_load_ready, w_load_fire, w_start_go, w_start_err;
    logic [IW-1:0]     w_j, w_i_inc, w_len_inc;
    logic              w_wrap, w_qzero;
    logic [DIM_W-1:0]  w_p_a, w_p_k, w_p_j;
    logic [COST_W-1:0] w_m_l, w_m_r, w_cand;
    logic [PW-1:0]     w_prod;

    function automatic logic [COST_W-1:0] sat_cost(input logic [SW-1:0] v);
        if (|v[SW-1:COST_W]) sat_cost = '1;
        else                 sat_cost = v[COST_W-1:0];
    endfunction

    assign w_j       = r_i + r_len - ONE;
    assign w_i_inc   = r_i + ONE;
    assign w_len_inc = r_len + ONE;
    assign w_wrap    = (w_i_inc > (r_n - r_len + ONE));

    // Diagonal entries are implicitly zero, so they are never stored or written.
    assign w_p_a  = r_p[AP'(r_i - ONE)];
    assign w_p_k  = r_p[AP'(r_k)];
    assign w_p_j  = r_p[AP'(w_j)];
    assign w_m_l  = (r_k == r_i)       ? '0 : r_m[AM'(r_i - ONE)][AM'(r_k - ONE)];
    assign w_m_r  = (r_k + ONE == w_j) ? '0 : r_m[AM'(r_k)][AM'(w_j - ONE)];
    assign w_prod = PW'(w_p_a) * PW'(w_p_k) * PW'(w_p_j);
    assign w_cand = sat_cost(SW'(w_m_l) + SW'(w_m_r) + SW'(w_prod));

    assign w_qzero = (bus.q_i == 8'd0) || (bus.q_j > r_num) || (bus.q_i >= bus.q_j);

    always_comb begin
        w_next       = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_load_ready = 1'b0;
        w_load_fire  = 1'b0;
        w_start_go   = 1'b0;
        w_start_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy       = 1'b0;
                w_load_ready = (r_cnt < IW'(MAX_N + 1));
                w_load_fire  = bus.load_valid && w_load_ready;
                // A load in the same cycle wins; start must be re-issued to see the new count.
                if (bus.start && !bus.clr && !w_load_fire) begin
                    if (r_cnt < IW'(2)) begin
                        w_start_err = 1'b1;
                    end else begin
                        w_start_go = 1'b1;
                        w_next     = S_INIT;
                    end
                end
            end
            S_INIT:    w_next = (r_n == ONE) ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (r_k == w_j - ONE) w_next = S_WRITE;
            S_WRITE:   w_next = (w_wrap && (w_len_inc > r_n)) ? S_DONE : S_COMPUTE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_num    <= '0;
            r_qv     <= 1'b0;
            r_qcost  <= '0;
            r_qsplit <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_start_err;
            if (r_state == S_IDLE && bus.clr) r_cnt <= '0;
            else if (w_load_fire)             r_cnt <= r_cnt + ONE;
            if (r_state != S_DONE && w_next == S_DONE) r_num <= r_n[7:0];
            r_qv <= (r_state == S_IDLE) && bus.q_valid;
            if (r_state == S_IDLE && bus.q_valid) begin
                if (w_qzero) begin
                    r_qcost  <= '0;
                    r_qsplit <= '0;
                end else begin
                    r_qcost  <= r_m[AM'(bus.q_i - 8'd1)][AM'(bus.q_j - 8'd1)];
                    r_qsplit <= r_s[AM'(bus.q_i - 8'd1)][AM'(bus.q_j - 8'd1)];
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (w_load_fire && !bus.clr) r_p[AP'(r_cnt)] <= bus.load_data;
        case (r_state)
            S_IDLE: if (w_start_go) r_n <= r_cnt - ONE;
            S_INIT: begin
                r_len <= IW'(2);
                r_i   <= ONE;
                r_k   <= ONE;
            end
            S_COMPUTE: begin
                // Strict compare keeps the smallest k on ties.
                if (r_k == r_i || w_cand < r_best) begin
                    r_best   <= w_cand;
                    r_best_k <= r_k[7:0];
                end
                r_k <= r_k + ONE;
            end
            S_WRITE: begin
                r_m[AM'(r_i - ONE)][AM'(w_j - ONE)] <= r_best;
                r_s[AM'(r_i - ONE)][AM'(w_j - ONE)] <= r_best_k;
                if (w_wrap) begin
                    r_len <= w_len_inc;
                    r_i   <= ONE;
                    r_k   <= ONE;
                end else begin
                    r_i <= w_i_inc;
                    r_k <= w_i_inc;
                end
            end
            default: ;
        endcase
    end

    assign bus.load_ready = w_load_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = r_err;
    assign bus.num_mats   = r_num;
    assign bus.q_rvalid   = r_qv;
    assign bus.q_cost     = r_qcost;
    assign bus.q_split    = r_qsplit;
endmodule
